// File: rtl/uart_pkg.sv
// Shared definitions for the UART loopback path: default widths/depths and the
// transmit pacing FSM state encoding used by the bridge.
package uart_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;
    localparam int ARM_TO_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRE  = 2'd1,
        ST_ARM   = 2'd2,
        ST_DRAIN = 2'd3
    } tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO between uart_recv and the transmit pacing FSM: storage,
// pointers, registered occupancy flags and a sticky overflow indicator.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              push_req,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              overflow_q, overflow_d;
    logic              push_ok;
    logic              pop_ok;

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        pop_ok     = pop && !empty_q;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok    = push_req && (!full_q || pop_ok);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else if (push_req) begin
            overflow_d = 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == FULL_CNT);
    end

    // NOTE: sequential state is assigned with <= only, so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and count
    // define which entries are valid, so stale contents are never observed.
    always_ff @(posedge sys_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign overflow = overflow_q;

endmodule : uart_byte_fifo

// File: rtl/uart_rx_fifo_bridge.sv
// Elastic buffer from uart_recv to uart_send: every received byte is queued and
// a pacing FSM hands bytes to the transmitter one at a time, obeying tx_busy.
module uart_rx_fifo_bridge
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ARM_TO = ARM_TO_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              rx_done,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_busy,
    output logic              tx_en,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              overflow
);

    localparam int ARM_W = (ARM_TO > 1) ? $clog2(ARM_TO) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TO - 1);
    localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1);

    tx_state_e         state_q, state_d;
    logic              tx_en_q, tx_en_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic              pop;
    logic [DATA_W-1:0] head_data;

    uart_byte_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .push_req  (rx_done),
        .push_data (rx_data),
        .pop       (pop),
        .rd_data   (head_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .overflow  (overflow)
    );

    always_comb begin
        state_d   = state_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        arm_cnt_d = arm_cnt_q;
        pop       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    tx_data_d = head_data;
                    tx_en_d   = 1'b1;
                    state_d   = ST_FIRE;
                end
            end
            ST_FIRE: begin
                arm_cnt_d = '0;
                state_d   = ST_ARM;
            end
            ST_ARM: begin
                // A transmitter that never acknowledges must not stall the queue.
                if (tx_busy) begin
                    state_d = ST_DRAIN;
                end else if (arm_cnt_q == ARM_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    arm_cnt_d = arm_cnt_q + ARM_ONE;
                end
            end
            ST_DRAIN: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            arm_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    assign tx_en   = tx_en_q;
    assign tx_data = tx_data_q;

endmodule : uart_rx_fifo_bridge

// File: tb/tb_uart_rx_fifo_bridge.sv
// Self-checking bench for uart_rx_fifo_bridge: a hand-computed vector table,
// directed corner sequences and random traffic against a timeline model.
module tb_uart_rx_fifo_bridge;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ARM_TO = 4;
    localparam int HORIZON = 8192;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              rx_done;
    logic [DATA_W-1:0] rx_data;
    logic              tx_busy;
    logic              tx_en;
    logic [DATA_W-1:0] tx_data;
    logic [4:0]        fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              overflow;

    uart_rx_fifo_bridge #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ARM_TO (ARM_TO)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .tx_busy    (tx_busy),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .fifo_count (fifo_count),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queue, sticky drop flag and a busy timeline. The
    // transmitter's busy windows are laid out per frame; the bridge may start
    // a new frame once the previous one is acknowledged and released, or once
    // ARM_TO cycles pass with no acknowledge.
    logic [DATA_W-1:0] m_q[$];
    bit                m_ovf;
    logic [DATA_W-1:0] m_last;
    bit                m_en;
    int                m_ready;
    int                cyc;
    bit                busy_at[HORIZON];
    int                frame_rise;
    int                frame_len;
    int                en_seen;

    task automatic set_frame(input int rise, input int len);
        frame_rise = rise;
        frame_len  = len;
    endtask

    task automatic schedule_frame(input int e);
        int k;
        int m;
        bit acked;
        for (int i = e + frame_rise; i < e + frame_rise + frame_len && i < HORIZON; i++)
            busy_at[i] = 1'b1;
        acked = 1'b0;
        m_ready = e + ARM_TO + 1;
        for (k = e + 1; k <= e + ARM_TO && !acked; k++) begin
            if (busy_at[k]) begin
                acked = 1'b1;
                m = k + 1;
                while (m < HORIZON - 1 && busy_at[m]) m++;
                m_ready = m + 1;
            end
        end
    endtask

    task automatic step(input logic rst, input logic rd, input logic [DATA_W-1:0] d);
        bit pop;
        bit push_ok;
        sys_rst = rst;
        rx_done = rd;
        rx_data = d;
        tx_busy = (cyc < HORIZON) ? busy_at[cyc] : 1'b0;
        if (rst) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_last  = '0;
            m_en    = 1'b0;
            m_ready = cyc + 1;
        end else begin
            pop     = (cyc >= m_ready) && (m_q.size() > 0);
            push_ok = rd && ((m_q.size() < DEPTH) || pop);
            m_en    = pop;
            if (pop) begin
                m_last = m_q.pop_front();
                schedule_frame(cyc + 1);
            end
            if (push_ok) m_q.push_back(d);
            else if (rd) m_ovf = 1'b1;
        end
        @(posedge sys_clk);
        cyc++;
        @(negedge sys_clk);
        if (tx_en) en_seen++;
        check("tx_en",      32'(tx_en),      32'(m_en));
        check("tx_data",    32'(tx_data),    32'(m_last));
        check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        check("fifo_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
        check("fifo_full",  32'(fifo_full),  32'(m_q.size() == DEPTH));
        check("overflow",   32'(overflow),   32'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    typedef struct {
        logic              rst;
        logic              rd;
        logic [DATA_W-1:0] d;
        logic              busy;
        logic              en;
        logic [DATA_W-1:0] data;
        int                cnt;
        logic              empty;
        logic              full;
        logic              ovf;
    } vec_t;

    vec_t vecs[32];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: 3-cycle reset, 0xA5 pushed, acknowledge 2 cycles after tx_en
        // lasting 20 cycles; 0x3C arrives mid-frame and leaves after release.
        for (int i = 0; i < 32; i++) begin
            vecs[i].rst   = (i < 3);
            vecs[i].rd    = 1'b0;
            vecs[i].d     = '0;
            vecs[i].busy  = (i >= 8 && i <= 27);
            vecs[i].en    = (i == 5 || i == 29);
            vecs[i].data  = (i < 5) ? 8'h00 : (i < 29) ? 8'hA5 : 8'h3C;
            vecs[i].cnt   = (i == 4 || (i >= 10 && i <= 28)) ? 1 : 0;
            vecs[i].empty = (vecs[i].cnt == 0);
            vecs[i].full  = 1'b0;
            vecs[i].ovf   = 1'b0;
        end
        vecs[4].rd  = 1'b1;
        vecs[4].d   = 8'hA5;
        vecs[10].rd = 1'b1;
        vecs[10].d  = 8'h3C;

        sys_rst = 1'b1;
        rx_done = 1'b0;
        rx_data = '0;
        tx_busy = 1'b0;
        cyc     = 0;
        en_seen = 0;
        m_ready = 0;
        m_last  = '0;
        m_ovf   = 1'b0;
        m_en    = 1'b0;
        set_frame(1, 3);
        @(negedge sys_clk);

        for (int i = 0; i < 32; i++) begin
            sys_rst = vecs[i].rst;
            rx_done = vecs[i].rd;
            rx_data = vecs[i].d;
            tx_busy = vecs[i].busy;
            @(posedge sys_clk);
            @(negedge sys_clk);
            check($sformatf("vec%0d.tx_en", i),    32'(tx_en),      32'(vecs[i].en));
            check($sformatf("vec%0d.tx_data", i),  32'(tx_data),    32'(vecs[i].data));
            check($sformatf("vec%0d.count", i),    32'(fifo_count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d.empty", i),    32'(fifo_empty), 32'(vecs[i].empty));
            check($sformatf("vec%0d.full", i),     32'(fifo_full),  32'(vecs[i].full));
            check($sformatf("vec%0d.overflow", i), 32'(overflow),   32'(vecs[i].ovf));
        end
        tx_busy = 1'b0;

        // Burst of five while a long frame is still in flight.
        step(1'b1, 1'b0, '0);
        set_frame(1, 30);
        step(1'b0, 1'b1, 8'hEE);
        idle(4);
        set_frame(1, 3);
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, DATA_W'(i));
        check("burst_count5", 32'(fifo_count), 32'd5);
        idle(60);
        check("burst_drained", 32'(fifo_empty), 32'd1);
        check("burst_last", 32'(tx_data), 32'h05);

        // Overflow: DEPTH+2 pushes while the transmitter is held busy.
        step(1'b1, 1'b0, '0);
        set_frame(1, 60);
        step(1'b0, 1'b1, 8'h77);
        idle(4);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b1, DATA_W'(8'h80 + i));
        check("ovf_full", 32'(fifo_full), 32'd1);
        check("ovf_count", 32'(fifo_count), 32'(DEPTH));
        check("ovf_flag", 32'(overflow), 32'd1);
        set_frame(1, 2);
        idle(DEPTH * 8 + 80);
        check("ovf_last_sent", 32'(tx_data), 32'(8'h80 + DEPTH - 1));
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO with a push landing in the same cycle as an IDLE pop.
        step(1'b1, 1'b0, '0);
        set_frame(1, 40);
        step(1'b0, 1'b1, 8'h55);
        idle(3);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, DATA_W'(8'h10 + i));
        check("sim_full", 32'(fifo_full), 32'd1);
        set_frame(1, 2);
        for (int k = 0; k < 200 && cyc < m_ready; k++) step(1'b0, 1'b0, '0);
        check("sim_reach_pop", 32'(cyc), 32'(m_ready));
        step(1'b0, 1'b1, 8'hC3);
        check("sim_count", 32'(fifo_count), 32'(DEPTH));
        check("sim_no_ovf", 32'(overflow), 32'd0);
        idle(DEPTH * 8 + 80);
        check("sim_last_byte", 32'(tx_data), 32'hC3);

        // No acknowledge at all: each frame times out and the next one goes.
        step(1'b1, 1'b0, '0);
        set_frame(1, 0);
        en_seen = 0;
        step(1'b0, 1'b1, 8'hA1);
        step(1'b0, 1'b1, 8'hA2);
        idle(20);
        check("timeout_pulses", 32'(en_seen), 32'd2);
        check("timeout_last", 32'(tx_data), 32'hA2);

        // Reset while draining discards the queued bytes.
        set_frame(1, 30);
        step(1'b0, 1'b1, 8'hB1);
        step(1'b0, 1'b1, 8'hB2);
        step(1'b0, 1'b1, 8'hB3);
        idle(5);
        step(1'b1, 1'b0, '0);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        en_seen = 0;
        idle(40);
        check("rst_no_more_tx", 32'(en_seen), 32'd0);

        // Random traffic, random acknowledge timing, rare resets.
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 800; i++) begin
            set_frame(int'($urandom_range(1, ARM_TO + 2)), int'($urandom_range(1, 6)));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 35,
                 DATA_W'($urandom_range(0, 255)));
        end
        set_frame(1, 2);
        idle(DEPTH * 10 + 40);
        check("random_drained", 32'(fifo_empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_uart_rx_fifo_bridge
